uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, byte width of every stream.
REQ-002 SHALL have parameter MAX_BURST, default 16, max beats per grant when tlast is absent; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports s0_tdata/s1_tdata  input  DATA_W  requester bytes.
REQ-006 SHALL have ports s0_tvalid/s1_tvalid  input  1  requester beat valid.
REQ-007 SHALL have ports s0_tlast/s1_tlast  input  1  last byte of requester packet.
REQ-008 SHALL have ports s0_tready/s1_tready  output  1  beat accepted from that requester.
REQ-009 SHALL have port m_tdata  output  DATA_W  byte to UART TX stream.
REQ-010 SHALL have port m_tvalid  output  1  output beat valid.
REQ-011 SHALL have port m_tlast  output  1  copy of accepted beat's tlast.
REQ-012 SHALL have port m_tready  input  1  UART TX ready.
REQ-013 SHALL have port grant  output  2  one-hot current owner; 2'b00 when idle.

Function
REQ-014 SHALL implement states IDLE, GRANT0, GRANT1.
REQ-015 In IDLE: s0_tvalid only -> GRANT0; s1_tvalid only -> GRANT1; both -> the requester not in last_served; neither -> stay IDLE.
REQ-016 Grant SHALL take effect the cycle after the request is seen in IDLE; no beat is accepted in IDLE.
REQ-017 sX_tready SHALL be 1 only in GRANTX and only when the output register is empty or m_tready=1; the other requester's tready SHALL be 0.
REQ-018 Output register SHALL be one entry; accepted beat appears on m_* the next cycle (latency 1); m_tdata/m_tlast SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-019 Simultaneous output drain and new accept SHALL sustain one beat per cycle.
REQ-020 Beat counter SHALL count accepted beats per grant, clear on entering a GRANT state, and never wrap.
REQ-021 Grant SHALL release to IDLE after the accepted beat with tlast=1 or the MAX_BURST-th beat, whichever comes first; last_served <= released owner.
REQ-022 Release SHALL NOT wait for the output register to drain; the next grant may overlap the drain.
REQ-023 Owner deasserting tvalid mid-packet SHALL keep the grant (no timeout).
REQ-024 grant SHALL be 2'b01 in GRANT0, 2'b10 in GRANT1, 2'b00 in IDLE.

Reset
REQ-025 On reset: state IDLE, last_served=1 (s0 wins first tie), counter 0, m_tvalid=0, m_tdata=0, m_tlast=0, grant=0, both tready=0.
REQ-026 Reset mid-packet SHALL discard any buffered beat and drop the grant without emitting a partial tail.

Structure
REQ-027 State encoding and DATA_W default SHALL live in shared package uart_loop_pkg.
REQ-028 The one-entry output register SHALL be sub-module axis_reg_slice (DATA_W+1 payload, valid/ready).
REQ-029 Arbiter FSM, counter and muxing SHALL reside in uart_tx_arbiter; no other sub-modules.

Verification
REQ-030 Single packet: s0 sends 0x41,0x42,0x43 (tlast on 0x43), m_tready=1 -> m_* emits same three bytes, first valid 2 cycles after s0_tvalid, grant returns 00 after 0x43 accepted.
REQ-031 Tie after reset: s0 and s1 both valid with 2-byte packets -> s0 packet fully, then s1 packet; no interleaving.
REQ-032 Fairness: both continuously valid, 1-byte packets 0xA0.. on s0, 0xB0.. on s1 -> output alternates A0,B0,A1,B1,...
REQ-033 No tlast, MAX_BURST=4, s0 streams 0x00..0x09 while s1 valid -> 4 s0 beats, s1 served, then s0 resumes at 0x04.
REQ-034 Backpressure: m_tready=0 for 5 cycles mid-packet -> m_tdata stable, no beat lost or duplicated, sX_tready=0 while full.
REQ-035 Reset asserted after 2nd of 4 beats -> next cycle m_tvalid=0, grant=0; new packet after reset transmits intact.

Source files
------------

// File: rtl/uart_loop_pkg.sv
// Shared types and defaults for the UART loopback transmit path.
// Arbiter state encoding doubles as the one-hot grant value.
package uart_loop_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT0 = 2'b01,
        ST_GRANT1 = 2'b10
    } arb_state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry valid/ready register slice; accepts a new beat in the same cycle
// the held beat drains, so a full-rate stream passes with one cycle latency.
module axis_reg_slice #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            // Payload only moves on a real beat so it stays put while idle.
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester packet arbiter feeding the UART TX stream through a one-entry
// output register; ties alternate, grants end on tlast or after MAX_BURST beats.
module uart_tx_arbiter
    import uart_loop_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic              s0_tvalid,
    input  logic              s0_tlast,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic              s1_tvalid,
    input  logic              s1_tlast,
    output logic              s1_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic [1:0]        grant
);

    arb_state_e  state_q, state_d;
    logic        last_q, last_d;   // 0: s0 served last, 1: s1 served last
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;

    logic              own_valid;
    logic              own_last;
    logic [DATA_W-1:0] own_data;
    logic              sl_valid;
    logic              sl_ready;
    logic              accept;

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = s0_tdata;
        if (state_q == ST_GRANT0) begin
            own_valid = s0_tvalid;
            own_last  = s0_tlast;
            own_data  = s0_tdata;
        end else if (state_q == ST_GRANT1) begin
            own_valid = s1_tvalid;
            own_last  = s1_tlast;
            own_data  = s1_tdata;
        end
    end

    assign sl_valid  = own_valid;
    assign accept    = own_valid && sl_ready;
    assign s0_tready = (state_q == ST_GRANT0) && sl_ready;
    assign s1_tready = (state_q == ST_GRANT1) && sl_ready;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant   = 2'b00;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (s0_tvalid && s1_tvalid) begin
                    state_d = last_q ? ST_GRANT0 : ST_GRANT1;
                end else if (s0_tvalid) begin
                    state_d = ST_GRANT0;
                end else if (s1_tvalid) begin
                    state_d = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                grant = (state_q == ST_GRANT0) ? 2'b01 : 2'b10;
                if (accept) begin
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_inc;
                    end
                    // Release immediately; the held beat drains under the next grant.
                    if (own_last || (cnt_inc == 8'(MAX_BURST))) begin
                        state_d = ST_IDLE;
                        last_d  = (state_q == ST_GRANT1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    axis_reg_slice #(
        .W (DATA_W + 1)
    ) u_out_reg (
        .clk         (clk),
        .reset       (reset),
        .in_data_i   ({own_last, own_data}),
        .in_valid_i  (sl_valid),
        .in_ready_o  (sl_ready),
        .out_data_o  ({m_tlast, m_tdata}),
        .out_valid_o (m_tvalid),
        .out_ready_i (m_tready)
    );

endmodule
